phase_timing_config: RTL and testbench
======================================

# phase_timing_config

Run-time configuration controller for the traffic-light phase sequencer. It turns the front-panel switches and buttons into debounced, edge-qualified increment and decrement events, and applies them to shadow copies of the four phase durations (forward, right, left, yellow). The edited set is committed to the active timing outputs only on a sequencer phase boundary, so a running cycle never sees a torn or mid-phase timing change.

## Interface
- `TW`, 8: width of each phase-time register (unsigned).
- `DEB_CYCLES`, 4: consecutive stable synchronized samples needed to change a debounced button level (≥2).
- `MIN_T`, 1: lower saturation bound for every phase time.
- `MAX_T`, 99: upper saturation bound for every phase time.
- `FWD_DEF` / `RGT_DEF` / `LFT_DEF` / `YEL_DEF`, 15 / 10 / 10 / 3: reset values.
- `REPEAT_CYCLES`, 8: hold time per auto-repeat step. Used only with `PTC_AUTOREPEAT_EN`.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `edit_en`  in  1: raw edit-mode switch (asynchronous).
- `sel`  in  2: phase select. 00 = yellow, 01 = left, 10 = right, 11 = forward.
- `btn_inc`  in  1: raw increment button (asynchronous, bouncy).
- `btn_dec`  in  1: raw decrement button (asynchronous, bouncy).
- `phase_boundary`  in  1: one-cycle pulse from the sequencer when it loads a new phase.
- `forward_t`, `right_t`, `left_t`, `yellow_t`  out  TW each: active phase times.
- `edit_val`  out  TW: shadow value of the currently selected phase, for display.
- `editing`  out  1: high in EDIT.
- `pending`  out  1: high in PENDING.
- `cfg_update`  out  1: one-cycle pulse when a commit occurs.

## Operation
- **Input synchronizers.** `edit_en`, `btn_inc` and `btn_dec` each pass through a 2-flop synchronizer. `sel` is sampled directly; it is a static switch.
- **Debounce.** Each button has its own counter. While the synced level differs from the debounced level, the counter increments. The debounced level flips when `DEB_CYCLES` consecutive differing samples have been seen. Any agreeing sample clears the counter.
- **Press event.** A press event is a rising edge of a debounced level, detected with one register stage.
- **States:**
  - IDLE → EDIT when the synced `edit_en` is 1.
  - EDIT → PENDING when the synced `edit_en` is 0.
  - PENDING → IDLE on `phase_boundary`. In that cycle, shadow is copied to active and `cfg_update` pulses on the next cycle.
  - PENDING → EDIT when the synced `edit_en` is 1. This cancels the commit and keeps the shadow values. It takes priority over a simultaneous `phase_boundary`.
- **Editing.** Only in EDIT, a press event updates the shadow register selected by the current `sel`:
  - An inc event adds 1, saturating at `MAX_T`.
  - A dec event subtracts 1, saturating at `MIN_T`.
  - Inc and dec events in the same cycle leave the value unchanged.
  - Press events outside EDIT are discarded.
- **Select changes.** Changing `sel` mid-edit is legal. Later events target the new phase, and `edit_val` follows `sel` combinationally.
- **Arithmetic.** Widen to TW+1 bits before compare and clamp. A register never wraps.
- **Active outputs.** Active registers change only on a commit.

## Timing
- **Reset.** Active and shadow registers take their `*_DEF` values. State is IDLE. `editing`, `pending` and `cfg_update` are 0. Debounce counters, debounced levels and synchronizers are 0. Reset mid-edit or mid-pending discards all shadow edits.
- **Press latency.** If raw `btn_inc` is first sampled high at edge 0 and is stable, the shadow changes at edge `DEB_CYCLES`+3.
- **Bounce rejection.** Any bounce shorter than `DEB_CYCLES` synced samples produces no event.
- **Commit latency.** With `phase_boundary` high at edge N, the active outputs update at edge N and `cfg_update` is high for the cycle after edge N. Because of this, the sequencer reloads with the new values no earlier than its next boundary.
- **Mode-switch latency.** `editing` and `pending` change 3 edges after the raw `edit_en` transition (2 sync stages + 1 state register).

## Configuration
- **`PTC_AUTOREPEAT_EN` defined.** While a debounced button stays high in EDIT, an extra event is generated every `REPEAT_CYCLES` cycles after the initial press event. Saturation rules are unchanged. Both buttons held: no repeats.
- **`PTC_AUTOREPEAT_EN` undefined.** Exactly one event per press. The repeat counter and its logic are absent.

## Structure
- **Shared package `tl_pkg`:**
  - phase-select encoding constants (`SEL_YELLOW`, `SEL_LEFT`, `SEL_RIGHT`, `SEL_FORWARD`);
  - the controller state enum (IDLE, EDIT, PENDING);
  - the default phase-time constants.
- **Sub-module `btn_debounce`.** Covers synchronizer, debounce counter, edge detect and optional auto-repeat. It is instantiated twice, for inc and dec.

## Test plan
1. **Reset.** Assert `reset` asynchronously mid-cycle → outputs 15/10/10/3, `editing`=0, `cfg_update`=0 immediately.
2. **Edit and commit.** Enter EDIT, set `sel`=11, make 2 clean inc presses. Leave EDIT, `pending`=1. Pulse `phase_boundary` → `forward_t`=17, one-cycle `cfg_update`, `edit_val`=17.
3. **Bounce and simultaneous presses.** Toggle `btn_dec` with 1–3 cycle pulses → no change. Press inc and dec together (`DEB_CYCLES`=4) → no change.
4. **Saturation.** With `sel`=00 and yellow at 3, make 5 dec presses → 1. With `sel`=01, set left to 99, then 1 inc → stays 99.
5. **Cancelled commit and ignored boundary.** Re-assert `edit_en` during PENDING together with `phase_boundary` → state EDIT, active unchanged, no `cfg_update`. A `phase_boundary` in IDLE → no update.
6. **Auto-repeat (`PTC_AUTOREPEAT_EN`).** Hold inc for `DEB_CYCLES`+3+3×`REPEAT_CYCLES` cycles on right=10 → 14. Without the macro → 11.

Source files
------------

// File: rtl/tl_pkg.sv
// tl_pkg: shared definitions for the traffic-light phase sequencer.
// Phase-select codes, controller state encoding and default phase times.
package tl_pkg;

    // Phase-select encoding; also the index into the phase-time arrays.
    localparam logic [1:0] SEL_YELLOW  = 2'b00;
    localparam logic [1:0] SEL_LEFT    = 2'b01;
    localparam logic [1:0] SEL_RIGHT   = 2'b10;
    localparam logic [1:0] SEL_FORWARD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EDIT    = 2'd1,
        ST_PENDING = 2'd2
    } ptc_state_e;

    // Reset values of the phase durations.
    localparam int FWD_DEF_C = 15;
    localparam int RGT_DEF_C = 10;
    localparam int LFT_DEF_C = 10;
    localparam int YEL_DEF_C = 3;

endpackage

// File: rtl/phase_timing_config_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, debounce counter and registered
// press-event detector for one raw button. Optional PTC_AUTOREPEAT_EN.
// Ports: clk, reset (async, high), btn_i (raw), event_o (1-cycle pulse);
// with PTC_AUTOREPEAT_EN also rpt_ok_i (repeat allowed), level_o.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
`ifdef PTC_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 8
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
`ifdef PTC_AUTOREPEAT_EN
    input  logic rpt_ok_i,
    output logic level_o,
`endif
    output logic event_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          deb_q;
    logic          prev_q;
    logic          ev_q;
    logic          fire;

`ifdef PTC_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    logic [RW-1:0] rpt_q;
    logic          rpt_run;

    // Repeat counting starts only once the rising edge has been seen,
    // so the first repeat lands REPEAT_CYCLES after the initial event.
    assign rpt_run = deb_q & prev_q & rpt_ok_i;
    assign fire    = rpt_run && (rpt_q == RW'(REPEAT_CYCLES - 1));
    assign level_o = deb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_q <= '0;
        end else if (rpt_run) begin
            rpt_q <= fire ? '0 : rpt_q + 1'b1;
        end else begin
            rpt_q <= '0;
        end
    end
`else
    assign fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
            prev_q <= 1'b0;
            ev_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            // Flip only after DEB_CYCLES consecutive disagreeing samples.
            if (sync_q[1] != deb_q) begin
                if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                    deb_q <= ~deb_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
            prev_q <= deb_q;
            ev_q   <= (deb_q & ~prev_q) | fire;
        end
    end

    assign event_o = ev_q;

endmodule

// File: rtl/phase_timing_config.sv
// phase_timing_config: edits shadow phase times from debounced buttons and
// commits them to the active outputs on a sequencer phase boundary.
// Ports: clk, reset, edit_en, sel, btn_inc, btn_dec, phase_boundary in;
// forward_t, right_t, left_t, yellow_t, edit_val, editing, pending,
// cfg_update out. Optional feature macro: PTC_AUTOREPEAT_EN.
module phase_timing_config
    import tl_pkg::*;
#(
    parameter int TW            = 8,
    parameter int DEB_CYCLES    = 4,
    parameter int MIN_T         = 1,
    parameter int MAX_T         = 99,
    parameter int FWD_DEF       = FWD_DEF_C,
    parameter int RGT_DEF       = RGT_DEF_C,
    parameter int LFT_DEF       = LFT_DEF_C,
    parameter int YEL_DEF       = YEL_DEF_C,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          edit_en,
    input  logic [1:0]    sel,
    input  logic          btn_inc,
    input  logic          btn_dec,
    input  logic          phase_boundary,
    output logic [TW-1:0] forward_t,
    output logic [TW-1:0] right_t,
    output logic [TW-1:0] left_t,
    output logic [TW-1:0] yellow_t,
    output logic [TW-1:0] edit_val,
    output logic          editing,
    output logic          pending,
    output logic          cfg_update
);

    localparam logic [TW:0] MAX_W = (TW+1)'(MAX_T);
    localparam logic [TW:0] MIN_W = (TW+1)'(MIN_T);

    ptc_state_e    state_q;
    logic [1:0]    edit_sync_q;
    logic [TW-1:0] sh_q  [4];
    logic [TW-1:0] act_q [4];
    logic          cfg_update_q;
    logic          inc_ev;
    logic          dec_ev;
    logic [TW:0]   cur_w;
    logic [TW:0]   nxt_w;
    logic [TW-1:0] sh_d;

`ifdef PTC_AUTOREPEAT_EN
    logic inc_lvl;
    logic dec_lvl;
    logic in_edit;

    assign in_edit = (state_q == ST_EDIT);

    btn_debounce #(
        .DEB_CYCLES   (DEB_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_inc (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_inc),
        .rpt_ok_i(in_edit & ~dec_lvl),
        .level_o (inc_lvl),
        .event_o (inc_ev)
    );

    btn_debounce #(
        .DEB_CYCLES   (DEB_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_dec (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_dec),
        .rpt_ok_i(in_edit & ~inc_lvl),
        .level_o (dec_lvl),
        .event_o (dec_ev)
    );
`else
    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_inc (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_inc),
        .event_o(inc_ev)
    );

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_dec (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_dec),
        .event_o(dec_ev)
    );
`endif

    // Saturating step in TW+1 bits so the value can never wrap.
    always_comb begin
        cur_w = {1'b0, sh_q[sel]};
        nxt_w = cur_w;
        if (inc_ev && !dec_ev) begin
            nxt_w = (cur_w >= MAX_W) ? MAX_W : cur_w + 1'b1;
        end else if (dec_ev && !inc_ev) begin
            nxt_w = (cur_w <= MIN_W) ? MIN_W : cur_w - 1'b1;
        end
        sh_d = TW'(nxt_w);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            edit_sync_q  <= '0;
            cfg_update_q <= 1'b0;
            sh_q[SEL_FORWARD]  <= TW'(FWD_DEF);
            sh_q[SEL_RIGHT]    <= TW'(RGT_DEF);
            sh_q[SEL_LEFT]     <= TW'(LFT_DEF);
            sh_q[SEL_YELLOW]   <= TW'(YEL_DEF);
            act_q[SEL_FORWARD] <= TW'(FWD_DEF);
            act_q[SEL_RIGHT]   <= TW'(RGT_DEF);
            act_q[SEL_LEFT]    <= TW'(LFT_DEF);
            act_q[SEL_YELLOW]  <= TW'(YEL_DEF);
        end else begin
            edit_sync_q  <= {edit_sync_q[0], edit_en};
            cfg_update_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (edit_sync_q[1]) state_q <= ST_EDIT;
                end
                ST_EDIT: begin
                    sh_q[sel] <= sh_d;
                    if (!edit_sync_q[1]) state_q <= ST_PENDING;
                end
                ST_PENDING: begin
                    // Re-entering edit wins over a coincident boundary.
                    if (edit_sync_q[1]) begin
                        state_q <= ST_EDIT;
                    end else if (phase_boundary) begin
                        state_q      <= ST_IDLE;
                        cfg_update_q <= 1'b1;
                        for (int i = 0; i < 4; i++) act_q[i] <= sh_q[i];
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign forward_t  = act_q[SEL_FORWARD];
    assign right_t    = act_q[SEL_RIGHT];
    assign left_t     = act_q[SEL_LEFT];
    assign yellow_t   = act_q[SEL_YELLOW];
    assign edit_val   = sh_q[sel];
    assign editing    = (state_q == ST_EDIT);
    assign pending    = (state_q == ST_PENDING);
    assign cfg_update = cfg_update_q;

endmodule

// File: tb/tb_phase_timing_config.sv
// tb_phase_timing_config: directed self-checking bench for
// phase_timing_config with default parameters.
module tb_phase_timing_config;

    logic       clk = 1'b0;
    logic       reset;
    logic       edit_en;
    logic [1:0] sel;
    logic       btn_inc;
    logic       btn_dec;
    logic       phase_boundary;
    logic [7:0] forward_t;
    logic [7:0] right_t;
    logic [7:0] left_t;
    logic [7:0] yellow_t;
    logic [7:0] edit_val;
    logic       editing;
    logic       pending;
    logic       cfg_update;

    int n_cmp = 0;
    int n_bad = 0;

    phase_timing_config dut (
        .clk           (clk),
        .reset         (reset),
        .edit_en       (edit_en),
        .sel           (sel),
        .btn_inc       (btn_inc),
        .btn_dec       (btn_dec),
        .phase_boundary(phase_boundary),
        .forward_t     (forward_t),
        .right_t       (right_t),
        .left_t        (left_t),
        .yellow_t      (yellow_t),
        .edit_val      (edit_val),
        .editing       (editing),
        .pending       (pending),
        .cfg_update    (cfg_update)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic up);
        if (up) btn_inc = 1'b1;
        else    btn_dec = 1'b1;
        tick(10);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        tick(10);
    endtask

    initial begin
        reset          = 1'b1;
        edit_en        = 1'b0;
        sel            = 2'b11;
        btn_inc        = 1'b0;
        btn_dec        = 1'b0;
        phase_boundary = 1'b0;
        #2;
        chk("rst_fwd", forward_t, 15);
        chk("rst_rgt", right_t, 10);
        chk("rst_lft", left_t, 10);
        chk("rst_yel", yellow_t, 3);
        chk("rst_editing", editing, 0);
        chk("rst_pending", pending, 0);
        chk("rst_cfg", cfg_update, 0);
        tick(2);
        reset = 1'b0;
        tick(2);

        // Enter EDIT: state flips on the 3rd edge after edit_en rises.
        edit_en = 1'b1;
        tick(2);
        chk("edit_lat_early", editing, 0);
        tick(1);
        chk("edit_lat", editing, 1);

        // First inc press: shadow moves on edge DEB_CYCLES+3 = 7.
        btn_inc = 1'b1;
        tick(7);
        chk("press_lat_early", edit_val, 15);
        tick(1);
        chk("press_lat", edit_val, 16);
        tick(2);
        btn_inc = 1'b0;
        tick(10);
        press(1'b1);
        chk("two_inc", edit_val, 17);
        chk("fwd_no_commit", forward_t, 15);

        edit_en = 1'b0;
        tick(3);
        chk("pend_on", pending, 1);
        chk("pend_edit_off", editing, 0);
        chk("fwd_pending", forward_t, 15);
        phase_boundary = 1'b1;
        tick(1);
        phase_boundary = 1'b0;
        chk("commit_fwd", forward_t, 17);
        chk("commit_cfg", cfg_update, 1);
        chk("commit_idle", pending, 0);
        tick(1);
        chk("cfg_one_cycle", cfg_update, 0);
        chk("commit_editval", edit_val, 17);

        // Bounce rejection and simultaneous presses.
        edit_en = 1'b1;
        tick(3);
        for (int w = 1; w <= 3; w++) begin
            btn_dec = 1'b1;
            tick(w);
            btn_dec = 1'b0;
            tick(4);
        end
        tick(10);
        chk("bounce", edit_val, 17);
        btn_inc = 1'b1;
        btn_dec = 1'b1;
        tick(10);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        tick(10);
        chk("inc_dec_same", edit_val, 17);

        // Saturation at MIN_T and MAX_T.
        sel = 2'b00;
        tick(1);
        chk("sel_yel", edit_val, 3);
        for (int i = 0; i < 5; i++) press(1'b0);
        chk("yel_min_sat", edit_val, 1);
        sel = 2'b01;
        tick(1);
        for (int i = 0; i < 89; i++) press(1'b1);
        chk("lft_99", edit_val, 99);
        press(1'b1);
        chk("lft_max_sat", edit_val, 99);
        chk("yel_active_hold", yellow_t, 3);

        // Cancel: edit_en returns together with a boundary in PENDING.
        edit_en = 1'b0;
        tick(3);
        chk("pend2", pending, 1);
        edit_en = 1'b1;
        tick(2);
        phase_boundary = 1'b1;
        tick(1);
        phase_boundary = 1'b0;
        chk("cancel_edit", editing, 1);
        chk("cancel_yel", yellow_t, 3);
        chk("cancel_lft", left_t, 10);
        chk("cancel_cfg", cfg_update, 0);
        tick(1);
        chk("cancel_cfg2", cfg_update, 0);
        chk("cancel_keep", edit_val, 99);

        // Commit, then a boundary while IDLE must do nothing.
        edit_en = 1'b0;
        tick(3);
        phase_boundary = 1'b1;
        tick(1);
        phase_boundary = 1'b0;
        chk("commit2_yel", yellow_t, 1);
        chk("commit2_lft", left_t, 99);
        chk("commit2_cfg", cfg_update, 1);
        tick(3);
        phase_boundary = 1'b1;
        tick(1);
        phase_boundary = 1'b0;
        chk("idle_bnd_cfg", cfg_update, 0);
        chk("idle_bnd_fwd", forward_t, 17);

        // Long hold on right=10.
        edit_en = 1'b1;
        sel     = 2'b10;
        tick(3);
        btn_inc = 1'b1;
        tick(31);
        btn_inc = 1'b0;
        tick(14);
`ifdef PTC_AUTOREPEAT_EN
        chk("hold_rgt", edit_val, 14);
`else
        chk("hold_rgt", edit_val, 11);
`endif
        chk("hold_rgt_active", right_t, 10);

        // Asynchronous reset mid-edit discards shadow edits.
        #3;
        reset = 1'b1;
        #1;
        chk("arst_editval", edit_val, 10);
        chk("arst_fwd", forward_t, 15);
        chk("arst_lft", left_t, 10);
        chk("arst_editing", editing, 0);
        chk("arst_cfg", cfg_update, 0);
        edit_en = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
